// File: rtl/full_idct_tp2.sv
// 8x8 inverse DCT: row pass into ping-pong transpose banks, column pass on readout.
// One registered 8-pixel column beat per cycle while a full bank drains.
module full_idct_tp2 #(
  parameter int LEVEL_SHIFT = 128,
  parameter int SHIFT       = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [95:0] in_row,
  output logic        out_valid,
  output logic [63:0] out_col,
  output logic [14:0] cnt_in,
  output logic [14:0] cnt_out
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  localparam int ROUND = 1 << (SHIFT - 1);

  // T[k][n]: basis function k sampled at position n, scaled by 2^SHIFT
  localparam logic signed [7:0] TBL [8][8] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       sat16 = 16'sh7fff;
    else if (v < -32'sd32768) sat16 = 16'sh8000;
    else                      sat16 = v[15:0];
  endfunction

  function automatic logic signed [15:0] row_dot(input logic [95:0] row, input int n);
    logic signed [31:0] acc;
    acc = ROUND;
    for (int k = 0; k < 8; k++)
      acc = acc + 32'(signed'(row[12*k +: 12])) * 32'(TBL[k][n]);
    return sat16(acc >>> SHIFT);
  endfunction

  function automatic logic [7:0] col_dot(input logic [127:0] col, input int i);
    logic signed [31:0] acc;
    acc = ROUND;
    for (int n = 0; n < 8; n++)
      acc = acc + 32'(signed'(col[16*n +: 16])) * 32'(TBL[n][i]);
    acc = (acc >>> SHIFT) + LEVEL_SHIFT;
    if (acc < 32'sd0)        return 8'd0;
    else if (acc > 32'sd255) return 8'd255;
    else                     return acc[7:0];
  endfunction

  bank_state_t  state_q [2];
  bank_state_t  state_d [2];
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [2:0]   wr_row_q, wr_row_d;
  logic [2:0]   rd_col_q, rd_col_d;
  logic         out_valid_q, out_valid_d;
  logic [63:0]  out_col_q, out_col_d;
  logic [14:0]  cnt_in_q, cnt_in_d;
  logic [14:0]  cnt_out_q, cnt_out_d;
  logic [127:0] bank_q [2][8];

  logic [127:0] y_row;
  logic [127:0] y_col;
  logic [63:0]  pix;
  logic         wr_fire;
  logic         rd_fire;

  always_comb begin
    y_row = '0;
    for (int n = 0; n < 8; n++)
      y_row[16*n +: 16] = row_dot(in_row, n);
  end

  // Column j of the read bank is the j-th 16-bit field of each stored row
  always_comb begin
    y_col = '0;
    for (int n = 0; n < 8; n++)
      y_col[16*n +: 16] = bank_q[rd_bank_q][n][16*rd_col_q +: 16];
    pix = '0;
    for (int i = 0; i < 8; i++)
      pix[8*i +: 8] = col_dot(y_col, i);
  end

  assign in_ready = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);

  // Writer only touches EMPTY/FILLING banks and reader only FULL/DRAINING, so updates never collide
  always_comb begin
    state_d[0]  = state_q[0];
    state_d[1]  = state_q[1];
    wr_bank_d   = wr_bank_q;
    wr_row_d    = wr_row_q;
    rd_bank_d   = rd_bank_q;
    rd_col_d    = rd_col_q;
    out_valid_d = rd_fire;
    out_col_d   = rd_fire ? pix : 64'd0;
    cnt_in_d    = cnt_in_q + 15'(wr_fire);
    cnt_out_d   = cnt_out_q + 15'(rd_fire);

    if (wr_fire) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        state_d[wr_bank_q] = FULL;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = FILLING;
      end
    end

    if (rd_fire) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        state_d[rd_bank_q] = EMPTY;
        rd_bank_d          = ~rd_bank_q;
      end else begin
        state_d[rd_bank_q] = DRAINING;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wr_bank_q   <= 1'b0;
      wr_row_q    <= 3'd0;
      rd_bank_q   <= 1'b0;
      rd_col_q    <= 3'd0;
      out_valid_q <= 1'b0;
      out_col_q   <= 64'd0;
      cnt_in_q    <= 15'd0;
      cnt_out_q   <= 15'd0;
    end else begin
      state_q[0]  <= state_d[0];
      state_q[1]  <= state_d[1];
      wr_bank_q   <= wr_bank_d;
      wr_row_q    <= wr_row_d;
      rd_bank_q   <= rd_bank_d;
      rd_col_q    <= rd_col_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      cnt_in_q    <= cnt_in_d;
      cnt_out_q   <= cnt_out_d;
    end
  end

  // Bank contents need no reset: the state machine gates every read
  always_ff @(posedge clk) begin
    if (wr_fire)
      bank_q[wr_bank_q][wr_row_q] <= y_row;
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign cnt_in    = cnt_in_q;
  assign cnt_out   = cnt_out_q;

endmodule

// File: tb/tb_full_idct_tp2.sv
// Directed bench for full_idct_tp2: hand-computed pixel blocks, latency, streaming, gaps, reset.
module tb_full_idct_tp2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_row;
  logic        out_valid;
  logic [63:0] out_col;
  logic [14:0] cnt_in;
  logic [14:0] cnt_out;

  always #5 clk = ~clk;

  full_idct_tp2 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_col   (out_col),
    .cnt_in    (cnt_in),
    .cnt_out   (cnt_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_drops = 0;
  int last_b0;
  int last_a0;

  int          acc_cyc  [$];
  int          beat_cyc [$];
  logic [63:0] beat_val [$];
  logic [95:0] stim_q   [$];
  logic [63:0] exp_q    [$];

  // (45*T[1][i] + 64) >>> 7 + 128 for i = 0..7
  logic [7:0] ramp [8] = '{8'd150, 8'd147, 8'd141, 8'd132, 8'd124, 8'd115, 8'd109, 8'd106};

  always @(posedge clk) cyc <= cyc + 1;

  // Sole writer of the observation queues; main code only reads them
  always @(negedge clk) begin
    if (reset && in_valid && in_ready)  acc_cyc.push_back(cyc);
    if (reset && in_valid && !in_ready) ready_drops <= ready_drops + 1;
    if (out_valid) begin
      beat_cyc.push_back(cyc);
      beat_val.push_back(out_col);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit gaps);
    int waitc;
    for (int r = 0; r < stim_q.size(); r++) begin
      if (gaps && r > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_row   = stim_q[r];
      waitc    = 0;
      while (!in_ready && waitc < 100) begin
        @(posedge clk); #1;
        waitc++;
      end
      if (waitc >= 100) checkOutput("ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_row   = '0;
  endtask

  task automatic add_block(input int r, input int k, input int v);
    logic [95:0] row;
    for (int i = 0; i < 8; i++) begin
      row = '0;
      if (i == r) row[12*k +: 12] = 12'(v);
      stim_q.push_back(row);
    end
  endtask

  task automatic expect_uniform(input logic [7:0] b);
    repeat (8) exp_q.push_back({8{b}});
  endtask

  task automatic expect_per_beat();
    for (int j = 0; j < 8; j++) exp_q.push_back({8{ramp[j]}});
  endtask

  task automatic expect_per_elem();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ramp[i];
    repeat (8) exp_q.push_back(w);
  endtask

  task automatic clear_plan();
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_row   = '0;
    reset    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_block(input string tag, input bit gaps);
    int n;
    int c;
    last_b0 = beat_val.size();
    last_a0 = acc_cyc.size();
    n = exp_q.size();
    applyStimulus(gaps);
    c = 0;
    while (beat_val.size() - last_b0 < n && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (12) @(posedge clk);
    #1;
    checkOutput({tag, " beats"}, 64'(beat_val.size() - last_b0), 64'(n));
    for (int j = 0; j < n && last_b0 + j < beat_val.size(); j++)
      checkOutput($sformatf("%s beat%0d", tag, j), beat_val[last_b0 + j], exp_q[j]);
    if (beat_val.size() - last_b0 >= n && acc_cyc.size() - last_a0 >= n) begin
      checkOutput({tag, " first"}, 64'(beat_cyc[last_b0]), 64'(acc_cyc[last_a0 + 7] + 2));
      checkOutput({tag, " contig"}, 64'(beat_cyc[last_b0 + n - 1]), 64'(beat_cyc[last_b0] + n - 1));
    end
  endtask

  initial begin
    int d0;
    int b0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_row   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst out_col",   out_col,        64'd0);
    checkOutput("rst cnt_in",    64'(cnt_in),    64'd0);
    checkOutput("rst cnt_out",   64'(cnt_out),   64'd0);
    checkOutput("rst in_ready",  64'(in_ready),  64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    clear_plan(); add_block(0, 0, 0); expect_uniform(8'h80);
    run_block("zero", 1'b0);
    if (beat_cyc.size() > last_b0 && acc_cyc.size() > last_a0)
      checkOutput("zero lat9", 64'(beat_cyc[last_b0]), 64'(acc_cyc[last_a0] + 9));
    checkOutput("zero cnt_out", 64'(cnt_out), 64'd8);
    checkOutput("zero cnt_in",  64'(cnt_in),  64'd8);

    clear_plan(); add_block(0, 0, 64);    expect_uniform(8'h88); run_block("dc64", 1'b0);
    clear_plan(); add_block(0, 0, 2047);  expect_uniform(8'hFF); run_block("satpos", 1'b0);
    clear_plan(); add_block(0, 0, -2048); expect_uniform(8'h00); run_block("satneg", 1'b0);
    clear_plan(); add_block(0, 1, 128);   expect_per_beat();     run_block("x01", 1'b0);
    clear_plan(); add_block(1, 0, 128);   expect_per_elem();     run_block("x10", 1'b0);

    do_reset();
    clear_plan();
    add_block(0, 0, 0);   expect_uniform(8'h80);
    add_block(0, 0, 64);  expect_uniform(8'h88);
    add_block(0, 1, 128); expect_per_beat();
    add_block(1, 0, 128); expect_per_elem();
    d0 = ready_drops;
    run_block("stream", 1'b0);
    checkOutput("stream ready", 64'(ready_drops - d0), 64'd0);
    checkOutput("stream cnt_in", 64'(cnt_in), 64'd32);
    checkOutput("stream cnt_out", 64'(cnt_out), 64'd32);
    if (beat_cyc.size() >= last_b0 + 32 && acc_cyc.size() > last_a0)
      checkOutput("stream last40", 64'(beat_cyc[last_b0 + 31]), 64'(acc_cyc[last_a0] + 40));

    clear_plan(); add_block(0, 1, 128); expect_per_beat(); run_block("gaps", 1'b1);

    b0 = beat_val.size();
    for (int r = 0; r < 5; r++) begin
      in_valid = 1'b1;
      in_row   = (r == 1) ? {84'd0, 12'd128} : 96'd0;
      @(posedge clk); #1;
    end
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midrst beats",   64'(beat_val.size() - b0), 64'd0);
    checkOutput("midrst cnt_in",  64'(cnt_in),  64'd0);
    checkOutput("midrst cnt_out", 64'(cnt_out), 64'd0);
    clear_plan(); add_block(1, 0, 128); expect_per_elem(); run_block("fresh", 1'b0);
    checkOutput("fresh cnt_in", 64'(cnt_in), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
